// File: rtl/div_seq_pkg.sv
// div_seq_pkg: shared definitions for the sequential divider.
// Holds the FSM state encodings, the DIV/DIVU ALU opcodes and the
// default of the DIV_ZERO_FAST_EN build option (left undefined).
//
// Uncomment to make divide-by-zero finish after one ZERO cycle
// instead of running the full constant-time WIDTH cycles:
// `define DIV_ZERO_FAST_EN

package div_seq_pkg;

    localparam int DIV_WIDTH = 32;

    localparam logic [7:0] ALU_DIV  = 8'b0001_1010;
    localparam logic [7:0] ALU_DIVU = 8'b0001_1011;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ZERO = 2'd1,
        ST_RUN  = 2'd2,
        ST_DONE = 2'd3
    } div_state_e;

endpackage : div_seq_pkg

// File: rtl/div_seq_if.sv
// div_seq_if: EX-stage <-> divider handshake bundle.
// master = execute stage, slave = divider sequencer.

interface div_seq_if #(
    parameter int WIDTH = 32
);

    logic                 signed_div_i;
    logic [WIDTH-1:0]     opdata1_i;
    logic [WIDTH-1:0]     opdata2_i;
    logic                 start_i;
    logic                 annul_i;
    logic [2*WIDTH-1:0]   result_o;
    logic                 ready_o;
    logic                 stallreq_o;

    modport master (
        output signed_div_i,
        output opdata1_i,
        output opdata2_i,
        output start_i,
        output annul_i,
        input  result_o,
        input  ready_o,
        input  stallreq_o
    );

    modport slave (
        input  signed_div_i,
        input  opdata1_i,
        input  opdata2_i,
        input  start_i,
        input  annul_i,
        output result_o,
        output ready_o,
        output stallreq_o
    );

endinterface : div_seq_if

// File: rtl/div_step.sv
// div_step: one combinational restoring-division iteration.
// Shifts the next dividend bit into the partial remainder and performs
// a WIDTH+1 bit trial subtract against the divisor.

module div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] partial_rem,
    input  logic [WIDTH-1:0] divisor,
    input  logic             dividend_bit,
    output logic [WIDTH-1:0] next_rem,
    output logic             quot_bit
);

    logic [WIDTH:0] shifted_s;
    logic [WIDTH:0] diff_s;

    // Trial subtract: keep the difference when it does not borrow.
    always_comb begin
        shifted_s = {partial_rem, dividend_bit};
        diff_s    = shifted_s - {1'b0, divisor};
        if (diff_s[WIDTH] == 1'b0) begin
            quot_bit = 1'b1;
            next_rem = diff_s[WIDTH-1:0];
        end else begin
            quot_bit = 1'b0;
            next_rem = shifted_s[WIDTH-1:0];
        end
    end

endmodule : div_step

// File: rtl/div_seq.sv
// div_seq: multi-cycle radix-2 restoring divider for DIV/DIVU.
// Produces {remainder, quotient}; asserts a stall request while busy.
// Build option: DIV_ZERO_FAST_EN shortens divide-by-zero to one cycle;
// without it divide-by-zero takes the same time as a real division.

module div_seq
    import div_seq_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic        clk,
    input  logic        rst,
    div_seq_if.slave    bus
);

    localparam int             CNT_W     = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    div_state_e           state_r;
    logic [CNT_W-1:0]     cnt_r;
    logic [WIDTH-1:0]     dvd_r;      // dividend shifts out, quotient shifts in
    logic [WIDTH-1:0]     dvs_r;
    logic [WIDTH-1:0]     rem_r;
    logic                 dvd_neg_r;
    logic                 dvs_neg_r;
    logic [2*WIDTH-1:0]   result_r;
    logic                 ready_r;

    logic [WIDTH-1:0]     rem_next_s;
    logic                 q_bit_s;
    logic [WIDTH-1:0]     quot_fix_s;
    logic [WIDTH-1:0]     rem_fix_s;
    logic                 op1_neg_s;
    logic                 op2_neg_s;

    // Two's complement negate when en is set, pass-through otherwise.
    function automatic logic [WIDTH-1:0] cond_neg(input logic [WIDTH-1:0] v,
                                                  input logic en);
        logic [WIDTH-1:0] one;
        one = {{(WIDTH-1){1'b0}}, 1'b1};
        cond_neg = en ? (~v + one) : v;
    endfunction

    div_step #(.WIDTH(WIDTH)) u_step (
        .partial_rem  (rem_r),
        .divisor      (dvs_r),
        .dividend_bit (dvd_r[WIDTH-1]),
        .next_rem     (rem_next_s),
        .quot_bit     (q_bit_s)
    );

    // Operand signs and the sign fix-up applied as the last step retires.
    always_comb begin
        op1_neg_s  = bus.signed_div_i & bus.opdata1_i[WIDTH-1];
        op2_neg_s  = bus.signed_div_i & bus.opdata2_i[WIDTH-1];
        quot_fix_s = cond_neg({dvd_r[WIDTH-2:0], q_bit_s}, dvd_neg_r ^ dvs_neg_r);
        rem_fix_s  = cond_neg(rem_next_s, dvd_neg_r);
    end

    // Divider FSM: operand capture, iteration, zero handling and result hold.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r   <= ST_IDLE;
            cnt_r     <= '0;
            dvd_r     <= '0;
            dvs_r     <= '0;
            rem_r     <= '0;
            dvd_neg_r <= 1'b0;
            dvs_neg_r <= 1'b0;
            result_r  <= '0;
            ready_r   <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    ready_r <= 1'b0;
                    if (bus.start_i && !bus.annul_i) begin
                        dvd_neg_r <= op1_neg_s;
                        dvs_neg_r <= op2_neg_s;
                        dvd_r     <= cond_neg(bus.opdata1_i, op1_neg_s);
                        dvs_r     <= cond_neg(bus.opdata2_i, op2_neg_s);
                        cnt_r     <= '0;
                        rem_r     <= '0;
                        if (bus.opdata2_i == '0) begin
                            state_r <= ST_ZERO;
                        end else begin
                            state_r <= ST_RUN;
                        end
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_ZERO: begin
                    if (bus.annul_i) begin
                        state_r <= ST_IDLE;
                        cnt_r   <= '0;
                    end else begin
`ifdef DIV_ZERO_FAST_EN
                        result_r <= '0;
                        ready_r  <= 1'b1;
                        state_r  <= ST_DONE;
`else
                        if (cnt_r == LAST_STEP) begin
                            result_r <= '0;
                            ready_r  <= 1'b1;
                            cnt_r    <= '0;
                            state_r  <= ST_DONE;
                        end else begin
                            cnt_r <= cnt_r + CNT_ONE;
                        end
`endif
                    end
                end
                ST_RUN: begin
                    if (bus.annul_i) begin
                        state_r <= ST_IDLE;
                        cnt_r   <= '0;
                    end else begin
                        rem_r <= rem_next_s;
                        dvd_r <= {dvd_r[WIDTH-2:0], q_bit_s};
                        if (cnt_r == LAST_STEP) begin
                            result_r <= {rem_fix_s, quot_fix_s};
                            ready_r  <= 1'b1;
                            cnt_r    <= '0;
                            state_r  <= ST_DONE;
                        end else begin
                            cnt_r <= cnt_r + CNT_ONE;
                        end
                    end
                end
                ST_DONE: begin
                    if (bus.annul_i || !bus.start_i) begin
                        ready_r <= 1'b0;
                        state_r <= ST_IDLE;
                    end else begin
                        ready_r <= 1'b1;
                        state_r <= ST_DONE;
                    end
                end
                default: begin
                    ready_r <= 1'b0;
                    cnt_r   <= '0;
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    // Stall is combinational so EX freezes in the issue cycle itself.
    assign bus.stallreq_o = rst & (((state_r == ST_IDLE) & bus.start_i & ~bus.annul_i)
                                   | (state_r == ST_ZERO)
                                   | (state_r == ST_RUN));
    assign bus.result_o = result_r;
    assign bus.ready_o  = ready_r;

endmodule : div_seq

// File: tb/tb_div_seq.sv
// tb_div_seq: directed self-checking bench for div_seq.
// Expected quotients/remainders are hand-computed constants.

module tb_div_seq;

    logic clk;
    logic rst;
    int   pass_cnt;
    int   total_cnt;

`ifdef DIV_ZERO_FAST_EN
    localparam int ZLAT = 2;
`else
    localparam int ZLAT = 33;
`endif
    localparam int LAT = 33;

    div_seq_if #(.WIDTH(32)) bus ();

    div_seq #(.WIDTH(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Free-running 10 ns clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total_cnt++;
        assert (obs === exp) begin
            pass_cnt++;
        end else begin
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Drive an operation from IDLE, check stall/ready every cycle and the result.
    task automatic do_op(input string tag, input logic sgn, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp_q,
                         input logic [31:0] exp_r, input int lat);
        bus.signed_div_i = sgn;
        bus.opdata1_i    = a;
        bus.opdata2_i    = b;
        bus.start_i      = 1'b1;
        for (int c = 0; c <= lat; c++) begin
            @(negedge clk);
            check($sformatf("%s stall c%0d", tag, c), {63'd0, bus.stallreq_o}, {63'd0, (c < lat)});
            check($sformatf("%s ready c%0d", tag, c), {63'd0, bus.ready_o}, {63'd0, (c == lat)});
            if (c == lat) begin
                check({tag, " result"}, bus.result_o, {exp_r, exp_q});
            end
            @(posedge clk); #1;
        end
        // start still high at the last edge: result held in DONE
        bus.start_i = 1'b0;
        @(negedge clk);
        check({tag, " hold ready"}, {63'd0, bus.ready_o}, 64'd1);
        check({tag, " hold result"}, bus.result_o, {exp_r, exp_q});
        @(posedge clk); #1;
        @(negedge clk);
        check({tag, " drop ready"}, {63'd0, bus.ready_o}, 64'd0);
        check({tag, " idle stall"}, {63'd0, bus.stallreq_o}, 64'd0);
        @(posedge clk); #1;
    endtask

    // Directed sequence.
    initial begin
        pass_cnt  = 0;
        total_cnt = 0;
        rst = 1'b0;
        bus.signed_div_i = 1'b0;
        bus.opdata1_i    = 32'd0;
        bus.opdata2_i    = 32'd0;
        bus.start_i      = 1'b0;
        bus.annul_i      = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        check("reset ready", {63'd0, bus.ready_o}, 64'd0);
        check("reset result", bus.result_o, 64'd0);
        check("reset stall", {63'd0, bus.stallreq_o}, 64'd0);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;

        do_op("u100_7", 1'b0, 32'd100, 32'd7, 32'd14, 32'd2, LAT);
        do_op("s-7_2", 1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, LAT);
        do_op("s_min_m1", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, LAT);
        do_op("u_min_m1", 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, LAT);
        do_op("u5_0", 1'b0, 32'd5, 32'd0, 32'd0, 32'd0, ZLAT);

        // start together with annul in IDLE must not launch anything
        bus.opdata1_i = 32'd9;
        bus.opdata2_i = 32'd3;
        bus.start_i   = 1'b1;
        bus.annul_i   = 1'b1;
        @(negedge clk);
        check("annul+start stall", {63'd0, bus.stallreq_o}, 64'd0);
        @(posedge clk); #1;
        bus.start_i = 1'b0;
        bus.annul_i = 1'b0;
        @(negedge clk);
        check("annul+start stall2", {63'd0, bus.stallreq_o}, 64'd0);
        check("annul+start ready", {63'd0, bus.ready_o}, 64'd0);
        @(posedge clk); #1;

        // abort a running division in cycle 10
        bus.signed_div_i = 1'b0;
        bus.opdata1_i    = 32'd1000;
        bus.opdata2_i    = 32'd7;
        bus.start_i      = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk); #1;
        end
        bus.annul_i = 1'b1;
        bus.start_i = 1'b0;
        @(negedge clk);
        check("annul c10 stall", {63'd0, bus.stallreq_o}, 64'd1);
        @(posedge clk); #1;
        bus.annul_i = 1'b0;
        @(negedge clk);
        check("annul c11 stall", {63'd0, bus.stallreq_o}, 64'd0);
        check("annul c11 ready", {63'd0, bus.ready_o}, 64'd0);
        begin
            int seen_ready;
            seen_ready = 0;
            for (int c = 0; c < 40; c++) begin
                @(negedge clk);
                if (bus.ready_o === 1'b1) seen_ready = 1;
            end
            check("annul no ready", seen_ready, 64'd0);
        end
        @(posedge clk); #1;
        do_op("u20_3", 1'b0, 32'd20, 32'd3, 32'd6, 32'd2, LAT);

        // synchronous reset in cycle 15 of a run
        bus.signed_div_i = 1'b0;
        bus.opdata1_i    = 32'd12345;
        bus.opdata2_i    = 32'd11;
        bus.start_i      = 1'b1;
        for (int c = 0; c < 15; c++) begin
            @(posedge clk); #1;
        end
        rst         = 1'b0;
        bus.start_i = 1'b0;
        @(negedge clk);
        check("rst c15 stall", {63'd0, bus.stallreq_o}, 64'd0);
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        check("rst c16 result", bus.result_o, 64'd0);
        check("rst c16 ready", {63'd0, bus.ready_o}, 64'd0);
        check("rst c16 stall", {63'd0, bus.stallreq_o}, 64'd0);
        @(posedge clk); #1;
        do_op("post_rst", 1'b0, 32'd100, 32'd7, 32'd14, 32'd2, LAT);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule : tb_div_seq
